// File: rtl/div_iter_axis.sv
// div_iter_axis: iterative restoring radix-2 divider with AXI-stream-style
// operand channels (divisor, dividend) and a one-cycle result pulse.
// One division in flight. Result is {quotient, remainder}.
// Optional build macro: DIV_EARLY_OUT_EN. When defined, a division by zero or
// one where |dividend| < |divisor| finishes straight after the entry cycle.
module div_iter_axis #(
    parameter int SIGNED = 1,
    parameter int WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
    input  logic                 s_axis_divisor_tvalid,
    output logic                 s_axis_divisor_tready,
    input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
    input  logic                 s_axis_dividend_tvalid,
    output logic                 s_axis_dividend_tready,
    output logic [2*WIDTH-1:0]   m_axis_dout_tdata,
    output logic                 m_axis_dout_tvalid
);

    localparam int   CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic IS_SIGNED = SIGNED[0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_r, state_next_s;

    logic               got_dvs_r, got_dnd_r;
    logic [WIDTH-1:0]   dvs_hold_r, dnd_hold_r;
    logic [WIDTH-1:0]   dvs_mag_r, dnd_raw_r;
    logic [WIDTH-1:0]   rem_r, quo_r;
    logic [CW-1:0]      cnt_r;
    logic               neg_q_r, neg_r_r, dvs_zero_r;
    logic [2*WIDTH-1:0] dout_tdata_r;
    logic               dout_tvalid_r;

    logic               dvs_ready_s, dnd_ready_s;
    logic               dvs_hs_s, dnd_hs_s, entry_s;
    logic [WIDTH-1:0]   dvs_cur_s, dnd_cur_s;
    logic [WIDTH:0]     shifted_s, trial_s;
    logic               fits_s;
    logic [WIDTH-1:0]   rem_next_s, quo_next_s;
    logic [2*WIDTH-1:0] fix_data_s;
    logic               early_s;
    logic [2*WIDTH-1:0] early_data_s;

    // Two's-complement negation.
    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
        neg_f = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of an operand; identity in unsigned mode.
    function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v);
        if (IS_SIGNED && v[WIDTH-1]) begin
            mag_f = neg_f(v);
        end else begin
            mag_f = v;
        end
    endfunction

    // A channel is ready only while idle and still waiting for its operand.
    assign dvs_ready_s = (state_r == S_IDLE) && !got_dvs_r;
    assign dnd_ready_s = (state_r == S_IDLE) && !got_dnd_r;
    assign dvs_hs_s    = s_axis_divisor_tvalid  && dvs_ready_s;
    assign dnd_hs_s    = s_axis_dividend_tvalid && dnd_ready_s;

    // The operand arriving in the entry cycle comes straight from the bus.
    assign dvs_cur_s = got_dvs_r ? dvs_hold_r : s_axis_divisor_tdata;
    assign dnd_cur_s = got_dnd_r ? dnd_hold_r : s_axis_dividend_tdata;
    assign entry_s   = (state_r == S_IDLE) && (got_dvs_r || dvs_hs_s) && (got_dnd_r || dnd_hs_s);

    // One restoring step: shift {rem,quo} left, keep the trial difference if it did not borrow.
    always_comb begin
        shifted_s  = {rem_r, quo_r[WIDTH-1]};
        trial_s    = shifted_s - {1'b0, dvs_mag_r};
        fits_s     = !trial_s[WIDTH];
        rem_next_s = fits_s ? trial_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
        quo_next_s = {quo_r[WIDTH-2:0], fits_s};
    end

    // Sign fix-up, with the divide-by-zero result overriding the iteration outcome.
    always_comb begin
        fix_data_s = {(neg_q_r ? neg_f(quo_r) : quo_r), (neg_r_r ? neg_f(rem_r) : rem_r)};
        if (dvs_zero_r) begin
            fix_data_s = {{WIDTH{1'b1}}, dnd_raw_r};
        end else begin
            fix_data_s = fix_data_s;
        end
    end

`ifdef DIV_EARLY_OUT_EN
    // In the first CALC cycle quo_r still holds |dividend|, so the compare is on magnitudes.
    assign early_s      = (state_r == S_CALC) && (cnt_r == CW'(WIDTH-1)) &&
                          (dvs_zero_r || (quo_r < dvs_mag_r));
    assign early_data_s = dvs_zero_r ? {{WIDTH{1'b1}}, dnd_raw_r} : {{WIDTH{1'b0}}, dnd_raw_r};
`else
    assign early_s      = 1'b0;
    assign early_data_s = {(2*WIDTH){1'b0}};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (entry_s) begin
                    state_next_s = S_CALC;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (early_s) begin
                    state_next_s = S_DONE;
                end else if (cnt_r == {CW{1'b0}}) begin
                    state_next_s = S_FIX;
                end else begin
                    state_next_s = S_CALC;
                end
            end
            S_FIX:   state_next_s = S_DONE;
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and registered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            got_dvs_r     <= 1'b0;
            got_dnd_r     <= 1'b0;
            dvs_hold_r    <= {WIDTH{1'b0}};
            dnd_hold_r    <= {WIDTH{1'b0}};
            dvs_mag_r     <= {WIDTH{1'b0}};
            dnd_raw_r     <= {WIDTH{1'b0}};
            rem_r         <= {WIDTH{1'b0}};
            quo_r         <= {WIDTH{1'b0}};
            cnt_r         <= {CW{1'b0}};
            neg_q_r       <= 1'b0;
            neg_r_r       <= 1'b0;
            dvs_zero_r    <= 1'b0;
            dout_tdata_r  <= {(2*WIDTH){1'b0}};
            dout_tvalid_r <= 1'b0;
        end else begin
            if (entry_s) begin
                got_dvs_r <= 1'b0;
                got_dnd_r <= 1'b0;
            end else begin
                if (dvs_hs_s) begin
                    got_dvs_r  <= 1'b1;
                    dvs_hold_r <= s_axis_divisor_tdata;
                end
                if (dnd_hs_s) begin
                    got_dnd_r  <= 1'b1;
                    dnd_hold_r <= s_axis_dividend_tdata;
                end
            end

            case (state_r)
                S_IDLE: begin
                    if (entry_s) begin
                        rem_r      <= {WIDTH{1'b0}};
                        quo_r      <= mag_f(dnd_cur_s);
                        dvs_mag_r  <= mag_f(dvs_cur_s);
                        dnd_raw_r  <= dnd_cur_s;
                        cnt_r      <= CW'(WIDTH-1);
                        neg_q_r    <= IS_SIGNED && (dnd_cur_s[WIDTH-1] ^ dvs_cur_s[WIDTH-1]);
                        neg_r_r    <= IS_SIGNED && dnd_cur_s[WIDTH-1];
                        dvs_zero_r <= (dvs_cur_s == {WIDTH{1'b0}});
                    end
                end
                S_CALC: begin
                    if (early_s) begin
                        dout_tdata_r <= early_data_s;
                    end else begin
                        rem_r <= rem_next_s;
                        quo_r <= quo_next_s;
                        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_FIX:   dout_tdata_r <= fix_data_s;
                default: dout_tdata_r <= dout_tdata_r;
            endcase

            dout_tvalid_r <= (state_next_s == S_DONE);
        end
    end

    assign s_axis_divisor_tready  = dvs_ready_s;
    assign s_axis_dividend_tready = dnd_ready_s;
    assign m_axis_dout_tdata      = dout_tdata_r;
    assign m_axis_dout_tvalid     = dout_tvalid_r;

endmodule

// File: tb/tb_div_iter_axis.sv
// Bench for div_iter_axis: a signed and an unsigned instance, directed vectors,
// and a cycle-by-cycle reference model of the channel/latency/result behaviour.
module tb_div_iter_axis;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO = 1;
`else
    localparam int EO = 0;
`endif
    localparam int LAT_FULL  = 34;
    localparam int LAT_SMALL = (EO != 0) ? 2 : 34;

    logic        clk;
    logic        reset;
    int          sel;
    logic [31:0] dvs_data, dnd_data;
    logic        dvs_valid, dnd_valid;

    logic        s_rdy_dvs, s_rdy_dnd, s_tv, u_rdy_dvs, u_rdy_dnd, u_tv;
    logic [63:0] s_td, u_td;
    logic        cur_rdy_dvs, cur_rdy_dnd, cur_tv;
    logic [63:0] cur_td;

    int n_vec, n_err, cyc;

    div_iter_axis #(.SIGNED(1), .WIDTH(32)) u_dut_s (
        .clk(clk), .reset(reset),
        .s_axis_divisor_tdata(dvs_data), .s_axis_divisor_tvalid(dvs_valid && (sel == 0)),
        .s_axis_divisor_tready(s_rdy_dvs),
        .s_axis_dividend_tdata(dnd_data), .s_axis_dividend_tvalid(dnd_valid && (sel == 0)),
        .s_axis_dividend_tready(s_rdy_dnd),
        .m_axis_dout_tdata(s_td), .m_axis_dout_tvalid(s_tv)
    );

    div_iter_axis #(.SIGNED(0), .WIDTH(32)) u_dut_u (
        .clk(clk), .reset(reset),
        .s_axis_divisor_tdata(dvs_data), .s_axis_divisor_tvalid(dvs_valid && (sel == 1)),
        .s_axis_divisor_tready(u_rdy_dvs),
        .s_axis_dividend_tdata(dnd_data), .s_axis_dividend_tvalid(dnd_valid && (sel == 1)),
        .s_axis_dividend_tready(u_rdy_dnd),
        .m_axis_dout_tdata(u_td), .m_axis_dout_tvalid(u_tv)
    );

    assign cur_rdy_dvs = (sel == 1) ? u_rdy_dvs : s_rdy_dvs;
    assign cur_rdy_dnd = (sel == 1) ? u_rdy_dnd : s_rdy_dnd;
    assign cur_tv      = (sel == 1) ? u_tv : s_tv;
    assign cur_td      = (sel == 1) ? u_td : s_td;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference result from plain integer arithmetic.
    function automatic logic [63:0] model_f(input int ii, input logic [31:0] dv, input logic [31:0] dn);
        int a, b;
        logic [31:0] q, r;
        if (dv == 32'd0) return {32'hFFFF_FFFF, dn};
        if (ii == 1) return {dn / dv, dn % dv};
        if (dn == 32'h8000_0000 && dv == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
        a = dn;
        b = dv;
        q = a / b;
        r = a % b;
        return {q, r};
    endfunction

    // Reference latency from the handshake cycle to the result pulse.
    function automatic int lat_f(input int ii, input logic [31:0] dv, input logic [31:0] dn);
        longint ma, mb;
        int sa, sb;
        sa = dn;
        sb = dv;
        if (ii == 0) begin
            ma = (sa < 0) ? -longint'(sa) : longint'(sa);
            mb = (sb < 0) ? -longint'(sb) : longint'(sb);
        end else begin
            ma = longint'({32'd0, dn});
            mb = longint'({32'd0, dv});
        end
        if ((EO != 0) && ((dv == 32'd0) || (ma < mb))) return 2;
        return 34;
    endfunction

    // Model state
    logic        chk_en, m_got_dvs, m_got_dnd, m_busy;
    logic [31:0] m_dvs, m_dnd;
    logic [63:0] m_exp;
    logic [63:0] m_data [0:1];
    int          m_done;

    // Model + per-cycle compare, sampled on the falling edge.
    initial begin : mon
        logic exp_v, rdy_d, rdy_n;
        chk_en = 1'b0; m_got_dvs = 1'b0; m_got_dnd = 1'b0; m_busy = 1'b0;
        m_dvs = 32'd0; m_dnd = 32'd0; m_exp = 64'd0; m_done = 0;
        m_data[0] = 64'd0; m_data[1] = 64'd0;
        forever begin
            @(negedge clk);
            exp_v = m_busy && (cyc == m_done);
            rdy_d = !m_busy && !m_got_dvs;
            rdy_n = !m_busy && !m_got_dnd;
            if (chk_en) begin
                if (exp_v) m_data[sel] = m_exp;
                chk("dout_tvalid", {63'd0, cur_tv}, {63'd0, exp_v});
                chk("dout_tdata", cur_td, m_data[sel]);
                chk("divisor_tready", {63'd0, cur_rdy_dvs}, {63'd0, rdy_d});
                chk("dividend_tready", {63'd0, cur_rdy_dnd}, {63'd0, rdy_n});
            end
            if (reset) begin
                chk_en = 1'b1; m_got_dvs = 1'b0; m_got_dnd = 1'b0; m_busy = 1'b0;
                m_data[0] = 64'd0; m_data[1] = 64'd0;
            end else if (chk_en) begin
                if (exp_v) m_busy = 1'b0;
                if (dvs_valid && rdy_d) begin m_got_dvs = 1'b1; m_dvs = dvs_data; end
                if (dnd_valid && rdy_n) begin m_got_dnd = 1'b1; m_dnd = dnd_data; end
                if (m_got_dvs && m_got_dnd) begin
                    m_exp = model_f(sel, m_dvs, m_dnd);
                    m_done = cyc + lat_f(sel, m_dvs, m_dnd);
                    m_busy = 1'b1;
                    m_got_dvs = 1'b0;
                    m_got_dnd = 1'b0;
                end
            end
        end
    end

    // Present both operands (each after its own offset) and hold until accepted.
    // Entered and left just after a rising edge; t0 is the later handshake cycle.
    task automatic present(input int ii, input logic [31:0] dv, input logic [31:0] dn,
                           input int off_d, input int off_n, output int t0);
        bit dd, nd;
        int k;
        dd = 1'b0; nd = 1'b0; k = 0; t0 = 0;
        sel = ii;
        while (!(dd && nd) && k < 200) begin
            dvs_data  = dv;
            dnd_data  = dn;
            dvs_valid = !dd && (k >= off_d);
            dnd_valid = !nd && (k >= off_n);
            @(negedge clk);
            if (dvs_valid && cur_rdy_dvs) begin dd = 1'b1; t0 = cyc; end
            if (dnd_valid && cur_rdy_dnd) begin nd = 1'b1; t0 = cyc; end
            @(posedge clk);
            #1;
            k = k + 1;
        end
        dvs_valid = 1'b0;
        dnd_valid = 1'b0;
        if (!(dd && nd)) begin
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $display("FAIL handshake timeout: got dd=%0d nd=%0d expected both 1", dd, nd);
        end
    endtask

    // Wait (bounded) for the result pulse and check latency and data against literals.
    task automatic await_result(input int t0, input logic [63:0] exp, input int lat, input string nm);
        int tv;
        tv = -1;
        for (int j = 0; j < 60 && tv < 0; j++) begin
            @(negedge clk);
            if (cur_tv) tv = cyc;
            @(posedge clk);
            #1;
        end
        if (tv < 0) begin
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $display("FAIL %s timeout: got no dout_tvalid expected one at T0+%0d", nm, lat);
        end else begin
            chk({nm, " latency"}, 64'(tv - t0), 64'(lat));
            chk({nm, " data"}, (sel == 1) ? u_td : s_td, exp);
        end
    endtask

    task automatic run(input int ii, input logic [31:0] dv, input logic [31:0] dn,
                       input int off_d, input int off_n, input logic [63:0] exp,
                       input int lat, input string nm);
        int t0;
        present(ii, dv, dn, off_d, off_n, t0);
        await_result(t0, exp, lat, nm);
    endtask

    initial begin
        int ta, tb;
        n_vec = 0; n_err = 0;
        reset = 1'b1; sel = 0;
        dvs_valid = 1'b0; dnd_valid = 1'b0; dvs_data = 32'd0; dnd_data = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset s divisor_tready", {63'd0, s_rdy_dvs}, 64'd1);
        chk("reset s dividend_tready", {63'd0, s_rdy_dnd}, 64'd1);
        chk("reset s tvalid", {63'd0, s_tv}, 64'd0);
        chk("reset s tdata", s_td, 64'd0);
        chk("reset u tdata", u_td, 64'd0);
        @(posedge clk);
        #1;

        run(1, 32'd7, 32'd100, 0, 0, 64'h0000000E_00000002, LAT_FULL, "u 100/7");
        run(0, 32'h0000_0002, 32'hFFFF_FFF9, 0, 0, 64'hFFFFFFFD_FFFFFFFF, LAT_FULL, "s -7/2");
        run(0, 32'hFFFF_FFFE, 32'h0000_0007, 0, 0, 64'hFFFFFFFD_00000001, LAT_FULL, "s 7/-2");
        run(0, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 64'h80000000_00000000, LAT_FULL, "s ovf");
        run(0, 32'd0, 32'd5, 0, 0, 64'hFFFFFFFF_00000005, LAT_SMALL, "s 5/0");
        run(1, 32'd0, 32'd5, 0, 0, 64'hFFFFFFFF_00000005, LAT_SMALL, "u 5/0");
        run(0, 32'd0, 32'hFFFF_FFF9, 0, 0, 64'hFFFFFFFF_FFFFFFF9, LAT_SMALL, "s -7/0");
        run(1, 32'd2, 32'hFFFF_FFFF, 0, 0, 64'h7FFFFFFF_00000001, LAT_FULL, "u max/2");
        run(1, 32'd2, 32'hFFFF_FFF9, 0, 0, 64'h7FFFFFFC_00000001, LAT_FULL, "u big/2");
        run(0, 32'd10, 32'd3, 0, 0, 64'h00000000_00000003, LAT_SMALL, "s 3/10");
        run(0, 32'd10, 32'hFFFF_FFFD, 0, 0, 64'h00000000_FFFFFFFD, LAT_SMALL, "s -3/10");
        run(0, 32'hFFFF_FFF9, 32'hFFFF_FF9C, 0, 0, 64'h0000000E_FFFFFFFE, LAT_FULL, "s -100/-7");
        run(0, 32'd10, 32'd1000, 0, 4, 64'h00000064_00000000, LAT_FULL, "stagger dvs first");
        run(1, 32'h10, 32'd12345, 3, 0, 64'h00000303_00000009, LAT_FULL, "stagger dnd first");

        // Back-to-back: second pair is held during CALC and accepted only after DONE.
        present(0, 32'd3, 32'h7FFF_FFFF, 0, 0, ta);
        fork
            await_result(ta, 64'h2AAAAAAA_00000001, LAT_FULL, "b2b first");
            present(0, 32'd4, 32'hFFFF_FFF7, 0, 0, tb);
        join
        chk("b2b accept cycle", 64'(tb - ta), 64'd35);
        await_result(tb, 64'hFFFFFFFE_FFFFFFFF, LAT_FULL, "b2b second");

        // Reset in the middle of a division aborts it.
        present(0, 32'd7, 32'd123456, 0, 0, ta);
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort divisor_tready", {63'd0, s_rdy_dvs}, 64'd1);
        chk("abort dividend_tready", {63'd0, s_rdy_dnd}, 64'd1);
        chk("abort tdata", s_td, 64'd0);
        repeat (30) begin @(posedge clk); #1; end
        run(0, 32'd3, 32'd9, 0, 0, 64'h00000003_00000000, LAT_FULL, "after abort 9/3");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
